// File: rtl/nvdla_csb_engine_pkg.sv
// Shared types and constants for the NVDLA CSB access engine.
// Holds the control/flag bundles and the engine state encoding.
package nvdla_package;

  localparam int unsigned NVDLA_CSB_ADDR_W = 16;
  localparam int unsigned NVDLA_CSB_DATA_W = 32;
  localparam logic [31:0] NVDLA_CSB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        clear;
    logic        enable;
    logic        start;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic        write;
    logic        wait_intr;
  } ctrl_engine_t;

  typedef struct packed {
    logic csb_valid;
    logic csb_wr_complete;
    logic intr;
    logic busy;
    logic error;
  } flags_engine_t;

  typedef enum logic [2:0] {
    ENG_IDLE,
    ENG_REQ,
    ENG_WAIT_RSP,
    ENG_PUSH,
    ENG_WAIT_INTR
  } state_engine_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE valid/ready stream interface.
// Ports: valid, ready, data[DATA_WIDTH], strb[DATA_WIDTH/8].
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport sink (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

endinterface

// File: rtl/nvdla_csb_engine_intr_capture.sv
// NVDLA interrupt rising-edge detector with a pending bit.
// Ports: intr_i level in; consume_i/clear_i; rise_o, pending_o.
module nvdla_intr_capture (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic intr_i,
  input  logic consume_i,
  output logic rise_o,
  output logic pending_o
);

  logic prev_q;
  logic pend_q;
  logic pend_d;

  assign rise_o    = intr_i & ~prev_q;
  assign pending_o = pend_q;

  // A consume only retires the edge already stored; a rise in the
  // same cycle is kept. When the consumer takes the rise directly
  // (pend_q low) nothing is left behind.
  always_comb begin
    pend_d = pend_q | rise_o;
    if (consume_i) begin
      pend_d = pend_q & rise_o;
    end
    if (clear_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= intr_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/nvdla_csb_engine.sv
// CSB access engine: one read, non-posted write or interrupt wait per start.
// Ports: ctrl_i/flags_o to FSM, csb2nvdla/nvdla2csb to NVDLA, rdata_o stream.
module nvdla_csb_engine
  import nvdla_package::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        test_mode_i,
  input  logic                        clear_i,
  input  ctrl_engine_t                ctrl_i,
  output flags_engine_t               flags_o,
  output logic                        csb2nvdla_valid_o,
  input  logic                        csb2nvdla_ready_i,
  output logic [NVDLA_CSB_ADDR_W-1:0] csb2nvdla_addr_o,
  output logic [NVDLA_CSB_DATA_W-1:0] csb2nvdla_wdat_o,
  output logic                        csb2nvdla_write_o,
  output logic                        csb2nvdla_nposted_o,
  input  logic                        nvdla2csb_valid_i,
  input  logic [NVDLA_CSB_DATA_W-1:0] nvdla2csb_data_i,
  input  logic                        nvdla2csb_wr_complete_i,
  input  logic                        dla_intr_i,
  hwpe_stream_intf_stream.source      rdata_o
);

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_engine_t state_q, state_d;

  logic [NVDLA_CSB_ADDR_W-1:0] addr_q;
  logic [NVDLA_CSB_DATA_W-1:0] wdat_q;
  logic                        write_q;
  logic [NVDLA_CSB_DATA_W-1:0] rdata_q;
  logic [31:0]                 cnt_q;
  logic                        error_q;
  logic                        wr_done_q, wr_done_d;
  logic                        intr_q, intr_d;

  logic clr_any;
  logic latch;
  logic cap_rsp;
  logic cap_to;
  logic set_err;
  logic consume;
  logic wd_hit;
  logic in_wait;
  logic cnt_rst;
  logic is_req;
  logic is_push;
  logic rise;
  logic pending;

  logic unused_test_mode;
  assign unused_test_mode = test_mode_i;

  assign clr_any = clear_i | ctrl_i.clear;
  assign is_req  = (state_q == ENG_REQ);
  assign is_push = (state_q == ENG_PUSH);
  assign in_wait = (state_q == ENG_WAIT_RSP) |
                   (state_q == ENG_WAIT_INTR);
  assign wd_hit  = WD_EN && in_wait && (cnt_q == WD_LAST);

  nvdla_intr_capture u_intr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clr_any),
    .intr_i    (dla_intr_i),
    .consume_i (consume),
    .rise_o    (rise),
    .pending_o (pending)
  );

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    cap_rsp   = 1'b0;
    cap_to    = 1'b0;
    set_err   = 1'b0;
    consume   = 1'b0;
    wr_done_d = 1'b0;
    intr_d    = 1'b0;
    unique case (state_q)
      ENG_IDLE: begin
        if (ctrl_i.start && ctrl_i.enable) begin
          latch   = 1'b1;
          state_d = ctrl_i.wait_intr ? ENG_WAIT_INTR : ENG_REQ;
        end
      end
      ENG_REQ: begin
        if (csb2nvdla_ready_i) begin
          state_d = ENG_WAIT_RSP;
        end
      end
      ENG_WAIT_RSP: begin
        if (write_q) begin
          if (nvdla2csb_wr_complete_i || wd_hit) begin
            set_err   = ~nvdla2csb_wr_complete_i;
            wr_done_d = 1'b1;
            state_d   = ENG_IDLE;
          end
        end else if (nvdla2csb_valid_i) begin
          cap_rsp = 1'b1;
          state_d = ENG_PUSH;
        end else if (wd_hit) begin
          set_err = 1'b1;
          cap_to  = 1'b1;
          state_d = ENG_PUSH;
        end
      end
      ENG_PUSH: begin
        if (rdata_o.ready) begin
          state_d = ENG_IDLE;
        end
      end
      ENG_WAIT_INTR: begin
        // Take a same-cycle rise directly to meet rise+1 latency.
        if (pending || rise) begin
          consume = 1'b1;
          intr_d  = 1'b1;
          state_d = ENG_IDLE;
        end else if (wd_hit) begin
          set_err = 1'b1;
          intr_d  = 1'b1;
          state_d = ENG_IDLE;
        end
      end
      default: state_d = ENG_IDLE;
    endcase
    if (clr_any) begin
      state_d   = ENG_IDLE;
      latch     = 1'b0;
      cap_rsp   = 1'b0;
      cap_to    = 1'b0;
      consume   = 1'b0;
      wr_done_d = 1'b0;
      intr_d    = 1'b0;
    end
  end

  assign cnt_rst = (state_d != state_q) &&
                   ((state_d == ENG_WAIT_RSP) ||
                    (state_d == ENG_WAIT_INTR));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ENG_IDLE;
      wr_done_q <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_done_q <= wr_done_d;
      intr_q    <= intr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdat_q  <= '0;
      write_q <= 1'b0;
    end else if (latch) begin
      addr_q  <= ctrl_i.addr;
      wdat_q  <= ctrl_i.wdat;
      write_q <= ctrl_i.write;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (cap_rsp) begin
      rdata_q <= nvdla2csb_data_i;
    end else if (cap_to) begin
      rdata_q <= NVDLA_CSB_TIMEOUT_RDATA;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_any || cnt_rst) begin
      cnt_q <= '0;
    end else if (in_wait) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      error_q <= 1'b0;
    end else if (clear_i) begin
      error_q <= 1'b0;
    end else if (set_err) begin
      error_q <= 1'b1;
    end
  end

  // Payload is gated so the bus idles at zero outside REQ.
  assign csb2nvdla_valid_o   = is_req;
  assign csb2nvdla_addr_o    = is_req ? addr_q : '0;
  assign csb2nvdla_wdat_o    = is_req ? wdat_q : '0;
  assign csb2nvdla_write_o   = is_req & write_q;
  assign csb2nvdla_nposted_o = is_req & write_q;

  assign rdata_o.valid = is_push;
  assign rdata_o.data  = rdata_q;
  assign rdata_o.strb  = '1;

  always_comb begin
    flags_o                 = '0;
    flags_o.csb_valid       = is_push & rdata_o.ready;
    flags_o.csb_wr_complete = wr_done_q;
    flags_o.intr            = intr_q;
    flags_o.busy            = (state_q != ENG_IDLE);
    flags_o.error           = error_q;
  end

endmodule

// File: tb/tb_nvdla_csb_engine.sv
// Directed plus randomized bench for nvdla_csb_engine.
// The bench plays the NVDLA register file and checks against a model map.
module tb_nvdla_csb_engine;
  import nvdla_package::*;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          test_mode_i = 1'b0;
  logic          clear_i = 1'b0;
  ctrl_engine_t  ctrl = '0;
  flags_engine_t flags;
  logic          csb_valid;
  logic          csb_ready = 1'b0;
  logic [15:0]   csb_addr;
  logic [31:0]   csb_wdat;
  logic          csb_write;
  logic          csb_nposted;
  logic          rsp_valid = 1'b0;
  logic [31:0]   rsp_data = '0;
  logic          wr_cmp = 1'b0;
  logic          dla_intr = 1'b0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) rdata_if ();

  nvdla_csb_engine #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .test_mode_i             (test_mode_i),
    .clear_i                 (clear_i),
    .ctrl_i                  (ctrl),
    .flags_o                 (flags),
    .csb2nvdla_valid_o       (csb_valid),
    .csb2nvdla_ready_i       (csb_ready),
    .csb2nvdla_addr_o        (csb_addr),
    .csb2nvdla_wdat_o        (csb_wdat),
    .csb2nvdla_write_o       (csb_write),
    .csb2nvdla_nposted_o     (csb_nposted),
    .nvdla2csb_valid_i       (rsp_valid),
    .nvdla2csb_data_i        (rsp_data),
    .nvdla2csb_wr_complete_i (wr_cmp),
    .dla_intr_i              (dla_intr),
    .rdata_o                 (rdata_if)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // mem: register file as the bus actually addressed it.
  // model: what the commanded transactions should have left behind.
  logic [31:0] mem   [logic [15:0]];
  logic [31:0] model [logic [15:0]];

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [15:0] a);
    return model.exists(a) ? model[a] : init_val(a);
  endfunction

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d,
                          input int nready, input int nrsp);
    logic [15:0] a_seen;
    ctrl.start = 1'b1; ctrl.enable = 1'b1;
    ctrl.write = 1'b1; ctrl.wait_intr = 1'b0;
    ctrl.addr = a; ctrl.wdat = d;
    tick;
    ctrl.start = 1'b0; ctrl.addr = ~a; ctrl.wdat = ~d;
    for (int i = 0; i <= nready; i++) begin
      chk1("wr_valid", csb_valid, 1'b1);
      chk32("wr_addr", 32'(csb_addr), 32'(a));
      chk32("wr_wdat", csb_wdat, d);
      chk1("wr_write", csb_write, 1'b1);
      chk1("wr_nposted", csb_nposted, 1'b1);
      if (i == nready) csb_ready = 1'b1;
      a_seen = csb_addr;
      if (i == nready) mem[a_seen] = csb_wdat;
      tick;
    end
    csb_ready = 1'b0;
    model[a] = d;
    chk1("wr_valid_drop", csb_valid, 1'b0);
    for (int i = 0; i < nrsp; i++) begin
      chk1("wr_cmp_early", flags.csb_wr_complete, 1'b0);
      tick;
    end
    wr_cmp = 1'b1;
    tick;
    wr_cmp = 1'b0;
    chk1("wr_cmp_pulse", flags.csb_wr_complete, 1'b1);
    chk1("wr_busy_done", flags.busy, 1'b0);
    tick;
    chk1("wr_cmp_one", flags.csb_wr_complete, 1'b0);
  endtask

  task automatic do_read(input logic [15:0] a, input int nrsp,
                         input int nbp);
    logic [15:0] a_seen;
    logic [31:0] exp;
    int          fires;
    fires = 0;
    exp = model_rd(a);
    ctrl.start = 1'b1; ctrl.enable = 1'b1;
    ctrl.write = 1'b0; ctrl.wait_intr = 1'b0;
    ctrl.addr = a; ctrl.wdat = $urandom;
    tick;
    ctrl.start = 1'b0; ctrl.addr = ~a;
    chk1("rd_valid", csb_valid, 1'b1);
    chk32("rd_addr", 32'(csb_addr), 32'(a));
    chk1("rd_nposted", csb_nposted, 1'b0);
    a_seen = csb_addr;
    csb_ready = 1'b1;
    tick;
    csb_ready = 1'b0;
    for (int i = 0; i < nrsp; i++) begin
      chk1("rd_rv_early", rdata_if.valid, 1'b0);
      tick;
    end
    rsp_valid = 1'b1;
    rsp_data = mem_rd(a_seen);
    tick;
    rsp_valid = 1'b0;
    rsp_data = $urandom;
    for (int i = 0; i < nbp; i++) begin
      chk1("rd_rv_hold", rdata_if.valid, 1'b1);
      chk32("rd_data_hold", rdata_if.data, exp);
      if (flags.csb_valid) fires++;
      tick;
    end
    rdata_if.ready = 1'b1;
    #1;
    chk1("rd_rv", rdata_if.valid, 1'b1);
    chk32("rd_data", rdata_if.data, exp);
    if (flags.csb_valid) fires++;
    tick;
    rdata_if.ready = 1'b0;
    chk1("rd_rv_drop", rdata_if.valid, 1'b0);
    chk1("rd_busy_done", flags.busy, 1'b0);
    chk32("rd_csb_valid_once", 32'(fires), 32'd1);
  endtask

  task automatic start_intr_wait;
    ctrl.start = 1'b1; ctrl.enable = 1'b1;
    ctrl.write = 1'b0; ctrl.wait_intr = 1'b1;
    tick;
    ctrl.start = 1'b0; ctrl.wait_intr = 1'b0;
  endtask

  initial begin
    logic [15:0] pool [4];
    rdata_if.ready = 1'b0;

    tick;
    tick;
    chk32("rst_flags", 32'(flags), 32'd0);
    chk1("rst_csb_valid", csb_valid, 1'b0);
    chk32("rst_addr", 32'(csb_addr), 32'd0);
    chk32("rst_wdat", csb_wdat, 32'd0);
    chk1("rst_nposted", csb_nposted, 1'b0);
    chk1("rst_rv", rdata_if.valid, 1'b0);
    chk32("rst_rdata", rdata_if.data, 32'd0);
    chk32("rst_strb", 32'(rdata_if.strb), 32'hF);
    rst_ni = 1'b1;
    tick;

    // start without enable is ignored
    ctrl.start = 1'b1; ctrl.enable = 1'b0;
    tick;
    ctrl.start = 1'b0;
    chk1("no_enable_idle", flags.busy, 1'b0);

    do_write(16'h0104, 32'h1, 3, 5);
    mem[16'h0000] = 32'h1234_5678;
    model[16'h0000] = 32'h1234_5678;
    do_read(16'h0000, 2, 4);
    do_read(16'h0104, 0, 0);

    for (int i = 0; i < 4; i++) pool[i] = 16'($urandom);
    for (int it = 0; it < 10; it++) begin
      logic [15:0] a;
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 6));
      else
        do_read(a, $urandom_range(0, 6), $urandom_range(0, 3));
    end

    // interrupt already pending before start
    dla_intr = 1'b1;
    tick;
    start_intr_wait;
    chk1("ip_busy", flags.busy, 1'b1);
    chk1("ip_intr_early", flags.intr, 1'b0);
    tick;
    chk1("ip_intr", flags.intr, 1'b1);
    chk1("ip_idle", flags.busy, 1'b0);
    tick;
    chk1("ip_intr_one", flags.intr, 1'b0);
    dla_intr = 1'b0;
    tick;

    // rise while waiting, then no stale pending
    start_intr_wait;
    for (int i = 0; i < 3; i++) begin
      chk1("iw_intr_early", flags.intr, 1'b0);
      tick;
    end
    dla_intr = 1'b1;
    tick;
    chk1("iw_intr_rise1", flags.intr, 1'b1);
    dla_intr = 1'b0;
    tick;
    start_intr_wait;
    tick;
    chk1("iw_no_stale", flags.intr, 1'b0);
    chk1("iw_no_stale_busy", flags.busy, 1'b1);
    dla_intr = 1'b1;
    tick;
    chk1("iw_intr2", flags.intr, 1'b1);
    dla_intr = 1'b0;
    tick;

    // rise coinciding with the consuming cycle is retained
    dla_intr = 1'b1;
    tick;
    dla_intr = 1'b0;
    start_intr_wait;
    dla_intr = 1'b1;
    tick;
    chk1("ic_intr_a", flags.intr, 1'b1);
    start_intr_wait;
    chk1("ic_busy_b", flags.busy, 1'b1);
    tick;
    chk1("ic_intr_b", flags.intr, 1'b1);
    dla_intr = 1'b0;
    tick;
    chk1("ic_error_none", flags.error, 1'b0);

    // read timeout
    ctrl.start = 1'b1; ctrl.enable = 1'b1;
    ctrl.write = 1'b0; ctrl.addr = 16'h0200;
    tick;
    ctrl.start = 1'b0;
    csb_ready = 1'b1;
    tick;
    csb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1("to_no_error", flags.error, 1'b0);
      tick;
    end
    chk1("to_error", flags.error, 1'b1);
    chk1("to_rv", rdata_if.valid, 1'b1);
    chk32("to_rdata", rdata_if.data, 32'hDEAD_BEEF);
    rdata_if.ready = 1'b1;
    tick;
    rdata_if.ready = 1'b0;
    chk1("to_idle", flags.busy, 1'b0);

    // ctrl clear during WAIT_RSP
    ctrl.start = 1'b1; ctrl.addr = 16'h0010;
    tick;
    ctrl.start = 1'b0;
    csb_ready = 1'b1;
    tick;
    csb_ready = 1'b0;
    tick;
    ctrl.clear = 1'b1;
    tick;
    ctrl.clear = 1'b0;
    chk1("clr_idle", flags.busy, 1'b0);
    rsp_valid = 1'b1;
    rsp_data = $urandom;
    tick;
    rsp_valid = 1'b0;
    chk1("clr_late_rv", rdata_if.valid, 1'b0);
    chk1("clr_late_busy", flags.busy, 1'b0);
    chk1("clr_error_kept", flags.error, 1'b1);
    do_read(16'h0010, 1, 0);
    clear_i = 1'b1;
    tick;
    clear_i = 1'b0;
    chk1("clear_i_error", flags.error, 1'b0);

    // asynchronous reset while in PUSH
    ctrl.start = 1'b1; ctrl.addr = 16'h0020;
    tick;
    ctrl.start = 1'b0;
    csb_ready = 1'b1;
    tick;
    csb_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = $urandom | 32'h1;
    tick;
    rsp_valid = 1'b0;
    chk1("rp_push", rdata_if.valid, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk1("rp_rv", rdata_if.valid, 1'b0);
    chk32("rp_rdata", rdata_if.data, 32'd0);
    chk32("rp_flags", 32'(flags), 32'd0);
    chk1("rp_csb_valid", csb_valid, 1'b0);
    tick;
    rst_ni = 1'b1;
    tick;
    chk1("rp_idle", flags.busy, 1'b0);
    chk1("rp_rv_after", rdata_if.valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
